// File: rtl/multiword_add_seq_pkg.sv
// Shared types and sizing helpers for the multiword sequential adder.
package mwadd_pkg;

    localparam int WORD_W_DEF    = 4;
    localparam int MAX_WORDS_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Word counter must hold 0..max_words inclusive.
    function automatic int CNT_W(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Operand-in / result-out stream bundle; slave is the adder wrapper's view.
interface multiword_add_seq_if #(
    parameter int WORD_W = mwadd_pkg::WORD_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] a_word;
    logic [WORD_W-1:0] b_word;
    logic              in_first;
    logic              in_last;
    logic              c_init;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] sum_word;
    logic              out_last;
    logic              c_out;

    modport slave (
        input  in_valid, a_word, b_word, in_first, in_last, c_init, out_ready,
        output in_ready, out_valid, sum_word, out_last, c_out
    );

    modport master (
        output in_valid, a_word, b_word, in_first, in_last, c_init, out_ready,
        input  in_ready, out_valid, sum_word, out_last, c_out
    );
endinterface

// File: rtl/multiword_add_seq_fulladder.sv
// N-bit combinational carry-propagate adder; zero latency, no flow control.
module FullAdderN #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
endmodule

// File: rtl/multiword_add_seq.sv
// Streams operand words LS-first through one adder, carrying between words; 1-cycle latency,
// single output register, in_ready = !out_valid || out_ready. MWADD_SUB_EN adds a subtract mode.
module multiword_add_seq
    import mwadd_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef MWADD_SUB_EN
    input  logic                  sub,
`endif
    multiword_add_seq_if.slave    bus,
    input  logic                  err_clr,
    output logic                  frame_err
);
    localparam int CW = CNT_W(MAX_WORDS);

    state_t            state, state_nxt;
    logic [CW-1:0]     word_cnt, cnt_nxt;
    logic              carry_q;
    logic              accept;
    logic              take_first;
    logic              overflow;
    logic              eff_last;
    logic              err_set;
    logic [WORD_W-1:0] add_b;
    logic              add_cin;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef MWADD_SUB_EN
    logic sub_q;
    logic sub_eff;

    // Mode is latched on the first word and held until the operation ends.
    assign sub_eff = take_first ? sub : sub_q;
    assign add_b   = sub_eff ? ~bus.b_word : bus.b_word;
    assign add_cin = take_first ? (sub_eff | bus.c_init & ~sub_eff) : carry_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sub_q <= 1'b0;
        else if (accept && take_first)
            sub_q <= sub;
    end
`else
    assign add_b   = bus.b_word;
    assign add_cin = take_first ? bus.c_init : carry_q;
`endif

    FullAdderN #(.N(WORD_W)) u_add (
        .a     (bus.a_word),
        .b     (add_b),
        .c_in  (add_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = word_cnt;
        // A word arriving in IDLE starts an operation even if in_first is missing.
        take_first = (state == IDLE) || bus.in_first;
        overflow   = (state == RUN) && !bus.in_first && !bus.in_last &&
                     (word_cnt == CW'(MAX_WORDS - 1));
        eff_last   = bus.in_last || overflow;
        err_set    = accept && (((state == IDLE) && !bus.in_first) ||
                                ((state == RUN) && bus.in_first) || overflow);
        if (accept) begin
            if (eff_last) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else if (take_first) begin
                state_nxt = RUN;
                cnt_nxt   = CW'(1);
            end else begin
                state_nxt = RUN;
                cnt_nxt   = word_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            carry_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_cnt <= cnt_nxt;
            if (accept)
                carry_q <= eff_last ? 1'b0 : add_cout;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.sum_word  <= '0;
            bus.out_last  <= 1'b0;
            bus.c_out     <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.sum_word  <= add_sum;
            bus.out_last  <= eff_last;
            bus.c_out     <= bus.in_last ? add_cout : 1'b0;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frame_err <= 1'b0;
        else if (err_set)
            frame_err <= 1'b1;
        else if (err_clr)
            frame_err <= 1'b0;
    end

endmodule
